arm_fetch: RTL and testbench
============================

ARM_FETCH -- requirements
Module: arm_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 30, word-address width (byte address bits [1:0] implicitly zero).
REQ-003 SHALL have parameter DATA_W, default 32, instruction width.
REQ-004 SHALL have parameter RESET_VECTOR, default 0, first word address fetched after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 halt_req  input  1  level; stop issuing fetches and drain.
REQ-008 redirect_valid  input  1  one-cycle pulse; flush and restart at redirect_addr.
REQ-009 redirect_addr  input  ADDR_W  new fetch word address.
REQ-010 imem_req_valid  output  1  fetch request valid.
REQ-011 imem_req_addr  output  ADDR_W  fetch word address.
REQ-012 imem_req_ready  input  1  memory accepts request.
REQ-013 imem_resp_valid  input  1  response valid; responses return in request order, latency >= 1.
REQ-014 imem_resp_data  input  DATA_W  fetched instruction.
REQ-015 inst_valid  output  1  queue head valid.
REQ-016 inst  output  DATA_W  queue head instruction.
REQ-017 inst_addr  output  ADDR_W  word address of queue head.
REQ-018 inst_ready  input  1  core consumes head.
REQ-019 halted  output  1  fetch stopped and no request outstanding.

Function
REQ-020 Request handshake = imem_req_valid && imem_req_ready; pop = inst_valid && inst_ready.
REQ-021 Fetch pc SHALL increment by 1 per accepted request, wrapping modulo 2^ADDR_W.
REQ-022 imem_req_valid SHALL be 1 only in state FETCH when occupancy + outstanding < DEPTH (credit rule); the queue SHALL never overflow.
REQ-023 imem_req_valid/addr SHALL stay stable until accepted, except on redirect or rst.
REQ-024 Outstanding counter (width clog2(DEPTH+1)) SHALL +1 on request handshake, -1 on response, unchanged when both.
REQ-025 Non-discarded response in cycle N SHALL appear at inst_valid in cycle N+1 with its request address; no combinational bypass.
REQ-026 Queue SHALL support simultaneous push and pop when full or empty without loss.
REQ-027 On redirect_valid: queue flushed (inst_valid=0 next cycle), pc := redirect_addr, and drop_cnt := outstanding after that cycle's handshake (including a request accepted that same cycle).
REQ-028 While drop_cnt > 0, each response SHALL be discarded and decrement drop_cnt; a response arriving in the redirect cycle itself is discarded.
REQ-029 Redirect SHALL take priority over pop, push and halt in the same cycle; state returns to FETCH unless halt_req=1.
REQ-030 States: FETCH (issue per REQ-022); DRAIN (no new requests, wait outstanding=0); HALTED.
REQ-031 FETCH->DRAIN when halt_req=1; DRAIN->HALTED when outstanding=0; HALTED->FETCH when halt_req=0, resuming at the held pc; DRAIN->FETCH if halt_req drops first.
REQ-032 halted SHALL be 1 only in HALTED; queued instructions remain poppable while halted.
REQ-033 inst_valid SHALL not depend combinationally on inst_ready.

Reset
REQ-034 rst asserted at any time, including mid-burst, SHALL set pc=RESET_VECTOR, queue empty, outstanding=0, drop_cnt=0, state FETCH.
REQ-035 During reset cycle outputs SHALL be imem_req_valid=0, inst_valid=0, halted=0; first request (addr RESET_VECTOR) in first cycle after rst deasserts.
REQ-036 In-flight responses from before reset SHALL NOT be expected; memory is reset by the same rst.

Structure
REQ-037 ADDR_W/DATA_W defaults and FETCH/DRAIN/HALTED encodings SHALL live in shared package arm_defs.
REQ-038 Queue SHALL be sub-module fetch_fifo (parametrised DEPTH x (ADDR_W+DATA_W) synchronous FIFO with full/empty/count).

Verification
REQ-039 Reset, ready=1, latency 1, inst_ready=1 -> requests addr 0,1,2,...; inst_addr 0 appears 2 cycles after first request.
REQ-040 inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; no overflow; resuming pops in order 0..3.
REQ-041 Redirect to 0x100 with 2 outstanding, latency 3 -> 2 responses dropped, next inst_addr=0x100, queue flushed.
REQ-042 halt_req=1 with 3 outstanding -> no new requests, halted=1 one cycle after last response; release resumes at next sequential pc.
REQ-043 pc=2^ADDR_W-1 (via redirect) -> next request addr 0.
REQ-044 rst pulsed mid-burst with queue half full -> inst_valid=0, next request addr RESET_VECTOR.

Source files
------------

// File: rtl/arm_defs.sv
// Shared definitions for the ARM instruction fetch front end.
package arm_defs;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue: DEPTH entries of WIDTH bits, with full/empty/count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 62,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/arm_fetch.sv
// Instruction fetch unit: credit-limited in-order requests, response queue,
// redirect flush with in-flight response dropping, and halt/drain control.
module arm_fetch
    import arm_defs::*;
#(
    parameter int                DEPTH        = 4,
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready,
    output logic              halted
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          QW      = ADDR_W + DATA_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] rsp_pc_nxt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_cnt_nxt;

    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic [QW-1:0]     q_rdata;
    logic              q_push;
    logic              q_pop;

    logic              credit_ok;
    logic              req_hs;
    logic              resp_in;
    logic              resp_keep;

    // Queued plus in-flight entries bound the queue, so accepted responses always fit.
    assign credit_ok      = ({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C;
    assign imem_req_valid = !rst && (state == ST_FETCH) && credit_ok;
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign resp_in   = imem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_in && !redirect_valid && (drop_cnt == '0);

    assign inst_valid       = !rst && !q_empty;
    assign {inst_addr, inst} = q_rdata;
    assign halted           = !rst && (state == ST_HALTED);

    assign q_pop  = inst_valid && inst_ready && !redirect_valid;
    assign q_push = resp_keep && (!q_full || q_pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (q_push),
        .wdata ({rsp_pc, imem_resp_data}),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        rsp_pc_nxt      = rsp_pc;
        outstanding_nxt = outstanding + CW'(req_hs) - CW'(resp_in);
        drop_cnt_nxt    = drop_cnt;

        if (req_hs)    pc_nxt     = pc + ADDR_W'(1);
        if (resp_keep) rsp_pc_nxt = rsp_pc + ADDR_W'(1);
        if (resp_in && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CW'(1);

        case (state)
            ST_FETCH: begin
                if (halt_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!halt_req)                   state_nxt = ST_FETCH;
                else if (outstanding_nxt == '0)  state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt_req) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase

        // Everything still in flight after this cycle, including a request accepted
        // now, belongs to the old stream and must be discarded on return.
        if (redirect_valid) begin
            pc_nxt       = redirect_addr;
            rsp_pc_nxt   = redirect_addr;
            drop_cnt_nxt = outstanding_nxt;
            state_nxt    = halt_req ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            rsp_pc      <= rsp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: cycle table plus redirect/wrap/halt/reset sequences.
module tb_arm_fetch;

    logic        clk;
    logic        rst;
    logic        halt_req;
    logic        redirect_valid;
    logic [29:0] redirect_addr;
    logic        imem_req_valid;
    logic [29:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_addr;
    logic        inst_ready;
    logic        halted;

    arm_fetch #(
        .DEPTH        (4),
        .ADDR_W       (30),
        .DATA_W       (32),
        .RESET_VECTOR (30'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_addr       (inst_addr),
        .inst_ready      (inst_ready),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic        rst;
        logic        iready;
        logic        exp_rv;
        logic [29:0] exp_ra;
        logic        exp_iv;
        logic [29:0] exp_ia;
        logic        exp_hl;
    } vec_t;

    mreq_t       mem_q[$];
    logic [29:0] sb_q[$];
    logic [29:0] model_pc;
    int unsigned mem_lat;
    int unsigned cyc;
    int          n_vec;
    int          n_bad;

    logic        s_rv;
    logic [29:0] s_ra;
    logic        s_iv;
    logic [29:0] s_ia;
    logic        s_hl;

    function automatic logic [31:0] mdata(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: memory drives its response, outputs sampled mid-cycle, models updated.
    task automatic cycle();
        logic        hs;
        logic        pop;
        logic [29:0] a;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        s_rv = imem_req_valid;
        s_ra = imem_req_addr;
        s_iv = inst_valid;
        s_ia = inst_addr;
        s_hl = halted;
        hs   = imem_req_valid && imem_req_ready;
        pop  = inst_valid && inst_ready;
        if (hs) begin
            check("req_addr", imem_req_addr, model_pc);
            sb_q.push_back(model_pc);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            model_pc = model_pc + 30'd1;
        end
        if (pop && !redirect_valid && !rst) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                a = sb_q.pop_front();
                check("inst_addr", inst_addr, a);
                check("inst_data", inst, mdata(a));
            end
        end
        if (imem_resp_valid) void'(mem_q.pop_front());
        if (redirect_valid) begin
            sb_q.delete();
            model_pc = redirect_addr;
        end
        if (rst) begin
            sb_q.delete();
            mem_q.delete();
            model_pc = 30'h0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_inst(input int unsigned budget);
        int unsigned n = 0;
        while (!s_iv && n < budget) begin
            cycle();
            n++;
        end
        check("wait_inst_bound", s_iv, 1);
    endtask

    task automatic wait_req(input int unsigned budget);
        int unsigned n = 0;
        while (!s_rv && n < budget) begin
            cycle();
            n++;
        end
        check("wait_req_bound", s_rv, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        mem_lat  = 1;
        model_pc = 30'h0;
        rst = 1'b1;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        inst_ready = 1'b0;

        // rst iready | rv ra | iv ia | halted   (latency 1, memory always ready)
        vt[0]  = '{1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 30'h0, 1'b0, 30'h0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 30'h1, 1'b0, 30'h0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 30'h2, 1'b1, 30'h0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 30'h3, 1'b1, 30'h0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 30'h0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 30'h4, 1'b1, 30'h1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b1, 30'h5, 1'b1, 30'h2, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b1, 30'h6, 1'b1, 30'h3, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b1, 30'h7, 1'b1, 30'h4, 1'b0};

        for (int i = 0; i < 13; i++) begin
            rst        = vt[i].rst;
            inst_ready = vt[i].iready;
            cycle();
            check("tbl_req_valid", s_rv, vt[i].exp_rv);
            check("tbl_inst_valid", s_iv, vt[i].exp_iv);
            check("tbl_halted", s_hl, vt[i].exp_hl);
            if (vt[i].exp_rv) check("tbl_req_addr", s_ra, vt[i].exp_ra);
            if (vt[i].exp_iv) check("tbl_inst_addr", s_ia, vt[i].exp_ia);
        end
        rst = 1'b0;

        // Redirect with two requests in flight, latency 3.
        mem_lat    = 3;
        inst_ready = 1'b1;
        reset_dut();
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 30'h100;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("redir_flush_iv", s_iv, 0);
        check("redir_req_valid", s_rv, 1);
        check("redir_req_addr", s_ra, 30'h100);
        wait_inst(20);
        check("redir_first_inst", s_ia, 30'h100);

        // Fetch pc wraps from all-ones to zero.
        redirect_valid = 1'b1;
        redirect_addr  = '1;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        wait_req(20);
        check("wrap_req_hi", s_ra, 30'h3FFF_FFFF);
        cycle();
        wait_req(20);
        check("wrap_req_zero", s_ra, 30'h0);
        for (int i = 0; i < 10; i++) cycle();

        // Halt with three outstanding, then release.
        mem_lat = 3;
        reset_dut();
        cycle();
        cycle();
        cycle();
        halt_req       = 1'b1;
        imem_req_ready = 1'b0;
        cycle();
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("drain_no_req", s_rv, 0);
            check("drain_not_halted", s_hl, 0);
        end
        cycle();
        check("halted_after_last_resp", s_hl, 1);
        check("halted_no_req", s_rv, 0);
        halt_req       = 1'b0;
        imem_req_ready = 1'b1;
        cycle();
        check("release_still_halted", s_hl, 1);
        cycle();
        check("resume_halted_low", s_hl, 0);
        check("resume_req_valid", s_rv, 1);
        check("resume_req_addr", s_ra, 30'h3);
        for (int i = 0; i < 8; i++) cycle();

        // Reset mid-burst with the queue partly filled.
        mem_lat    = 1;
        inst_ready = 1'b0;
        reset_dut();
        cycle();
        cycle();
        cycle();
        check("burst_queue_filled", s_iv, 1);
        rst = 1'b1;
        cycle();
        check("rst_req_valid", s_rv, 0);
        check("rst_inst_valid", s_iv, 0);
        check("rst_halted", s_hl, 0);
        rst = 1'b0;
        cycle();
        check("post_rst_req_valid", s_rv, 1);
        check("post_rst_req_addr", s_ra, 30'h0);
        check("post_rst_inst_valid", s_iv, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
